// File: rtl/unit_clause_evaluator.sv
// Unit-clause detector for one SAT clause: flags a clause with exactly one active
// unassigned literal and reports that literal's variable and satisfying value.
module unit_clause_evaluator #(
  parameter  int VAR_PER_CLAUSE       = 5,
  parameter  int NUM_VARIABLE         = 128,
  localparam int VAR_PER_CLAUSE_INDEX = VAR_PER_CLAUSE - 1,
  localparam int VARIABLE_INDEX       = $clog2(NUM_VARIABLE) - 1
) (
  input  logic                                              clock,
  input  logic                                              reset_n,
  input  logic [VAR_PER_CLAUSE_INDEX:0]                     unassign,
  input  logic [VAR_PER_CLAUSE_INDEX:0]                     clause_mask,
  input  logic [VAR_PER_CLAUSE_INDEX:0]                     clause_pole,
  input  logic [VAR_PER_CLAUSE_INDEX:0][VARIABLE_INDEX:0]   variable,
  output logic                                              new_assignment,
  output logic [VARIABLE_INDEX:0]                           implied_variable,
  output logic                                              is_unit_clause
);

  logic [VAR_PER_CLAUSE_INDEX:0] cand;
  logic                          seen_one;
  logic                          seen_many;
  logic                          unit;
  logic                          sel_pole;
  logic [VARIABLE_INDEX:0]       sel_var;

  // Masked-out slots must neither count nor select, so filter before anything else.
  assign cand = unassign & clause_mask;

  // Population-count-equals-one via two sticky flags; the OR-select is exact
  // only when a single bit is set, which is why it is gated by unit below.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    seen_one  = 1'b0;
    seen_many = 1'b0;
    sel_pole  = 1'b0;
    sel_var   = '0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (cand[i]) begin
        seen_many = seen_many | seen_one;
        seen_one  = 1'b1;
        sel_pole  = sel_pole | clause_pole[i];
        sel_var   = sel_var | variable[i];
      end
    end
    unit = seen_one & ~seen_many;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_unit_clause   <= 1'b0;
      new_assignment   <= 1'b0;
      implied_variable <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all three outputs
      // update together from the same sampled inputs.
      is_unit_clause   <= unit;
      new_assignment   <= unit & sel_pole;
      implied_variable <= unit ? sel_var : '0;
    end
  end

endmodule

// File: tb/tb_unit_clause_evaluator.sv
// Directed, table-driven bench for unit_clause_evaluator with reset corner-case sequences.
module tb_unit_clause_evaluator;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic [4:0]       unassign;
  logic [4:0]       clause_mask;
  logic [4:0]       clause_pole;
  logic [4:0][6:0]  variable;
  logic             new_assignment;
  logic [6:0]       implied_variable;
  logic             is_unit_clause;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string           name;
    logic [4:0]      un;
    logic [4:0]      mask;
    logic [4:0]      pole;
    logic [4:0][6:0] vars;
    logic            exp_unit;
    logic [6:0]      exp_var;
    logic            exp_assign;
  } vec_t;

  vec_t vecs[10];

  unit_clause_evaluator #(.VAR_PER_CLAUSE(5), .NUM_VARIABLE(128)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .unassign         (unassign),
    .clause_mask      (clause_mask),
    .clause_pole      (clause_pole),
    .variable         (variable),
    .new_assignment   (new_assignment),
    .implied_variable (implied_variable),
    .is_unit_clause   (is_unit_clause)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic u, input logic [6:0] v, input logic a);
    check({name, ".is_unit"}, {31'd0, is_unit_clause}, {31'd0, u});
    check({name, ".implied"}, {25'd0, implied_variable}, {25'd0, v});
    check({name, ".assign"},  {31'd0, new_assignment}, {31'd0, a});
  endtask

  task automatic drive(input vec_t v);
    unassign    = v.un;
    clause_mask = v.mask;
    clause_pole = v.pole;
    variable    = v.vars;
  endtask

  function automatic vec_t mk(input string n, input logic [4:0] un, input logic [4:0] mask,
                              input logic [4:0] pole, input logic [34:0] vars,
                              input logic eu, input logic [6:0] ev, input logic ea);
    vec_t v;
    v.name = n; v.un = un; v.mask = mask; v.pole = pole; v.vars = vars;
    v.exp_unit = eu; v.exp_var = ev; v.exp_assign = ea;
    return v;
  endfunction

  initial begin
    // Ordered so unit and non-unit clauses alternate every cycle.
    vecs[0] = mk("unit_neg",   5'b10000, 5'b11111, 5'b00000, {7'd42, 7'd3, 7'd2, 7'd1, 7'd7},   1'b1, 7'd42,  1'b0);
    vecs[1] = mk("two_unasg",  5'b10001, 5'b11111, 5'b11111, {7'd11, 7'd12, 7'd13, 7'd14, 7'd15}, 1'b0, 7'd0,  1'b0);
    vecs[2] = mk("unit_pos",   5'b10000, 5'b11111, 5'b11111, {7'd99, 7'd3, 7'd2, 7'd1, 7'd7},   1'b1, 7'd99,  1'b1);
    vecs[3] = mk("all_unasg",  5'b11111, 5'b11111, 5'b10101, {7'd1, 7'd2, 7'd3, 7'd4, 7'd5},    1'b0, 7'd0,   1'b0);
    vecs[4] = mk("mask_filt",  5'b10100, 5'b00111, 5'b00100, {7'd77, 7'd9, 7'd5, 7'd8, 7'd6},   1'b1, 7'd5,   1'b1);
    vecs[5] = mk("none_unasg", 5'b00000, 5'b11111, 5'b11111, {7'd20, 7'd21, 7'd22, 7'd23, 7'd24}, 1'b0, 7'd0,  1'b0);
    vecs[6] = mk("slot0_neg",  5'b00001, 5'b00001, 5'b11110, {7'd30, 7'd31, 7'd32, 7'd33, 7'd127}, 1'b1, 7'd127, 1'b0);
    vecs[7] = mk("mask_zero",  5'b11111, 5'b00000, 5'b11111, {7'd40, 7'd41, 7'd42, 7'd43, 7'd44}, 1'b0, 7'd0,  1'b0);
    vecs[8] = mk("slot3_pos",  5'b01010, 5'b01000, 5'b01000, {7'd50, 7'd64, 7'd52, 7'd53, 7'd54}, 1'b1, 7'd64, 1'b1);
    vecs[9] = mk("mid_two",    5'b00110, 5'b11111, 5'b00110, {7'd60, 7'd61, 7'd62, 7'd63, 7'd65}, 1'b0, 7'd0,  1'b0);

    // Reset with a unit clause on the inputs: outputs clear before any clock edge.
    drive(vecs[2]);
    #2 reset_n = 1'b0;
    #1 check_all("reset_async", 1'b0, 7'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1 check_all("reset_hold", 1'b0, 7'd0, 1'b0);

    @(negedge clock);
    unassign = '0; clause_mask = '0; clause_pole = '0; variable = '0;
    reset_n = 1'b1;
    @(posedge clock);
    #1 check_all("post_reset_zero", 1'b0, 7'd0, 1'b0);

    // Back-to-back: a new clause every cycle, each result checked after its edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      @(posedge clock);
      #1 check_all(vecs[i].name, vecs[i].exp_unit, vecs[i].exp_var, vecs[i].exp_assign);
    end

    // Reset between edges discards a unit result immediately.
    @(negedge clock);
    drive(vecs[0]);
    @(posedge clock);
    #1 check_all("pre_midreset", 1'b1, 7'd42, 1'b0);
    #1 reset_n = 1'b0;
    #1 check_all("midreset_async", 1'b0, 7'd0, 1'b0);
    @(posedge clock);
    #1 check_all("midreset_edge", 1'b0, 7'd0, 1'b0);
    @(negedge clock);
    drive(vecs[8]);
    reset_n = 1'b1;
    @(posedge clock);
    #1 check_all("first_after_reset", 1'b1, 7'd64, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/unit_clause_evaluator.md
# unit_clause_evaluator

Per-clause unit-propagation evaluator for the SAT solver datapath (instantiated inside `sat_solver`). Each cycle it takes one clause's literal slots: variable IDs, polarities, slot-valid mask and per-slot unassigned flags. It decides whether the clause is a unit clause, meaning exactly one active literal is still unassigned. If so, it reports that literal's variable ID and the value that satisfies it. Results are registered and feed the solver's implication/assignment logic.

## Interface
- `VAR_PER_CLAUSE`, default 5: literal slots per clause.
- `NUM_VARIABLE`, default 128: number of solver variables.
- Derived localparams:
  - `VAR_PER_CLAUSE_INDEX = VAR_PER_CLAUSE-1`.
  - `VARIABLE_INDEX = $clog2(NUM_VARIABLE)-1` (6 at defaults).
- `clock`  input  1: single clock; all state updates on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `unassign`  input  VAR_PER_CLAUSE: bit i = 1 means slot i's variable is currently unassigned.
- `clause_mask`  input  VAR_PER_CLAUSE: bit i = 1 means slot i holds a real literal. Slots with bit i = 0 are ignored entirely.
- `clause_pole`  input  VAR_PER_CLAUSE: bit i = polarity of slot i (1 = positive literal x, 0 = negated literal ¬x).
- `variable`  input  [VAR_PER_CLAUSE_INDEX:0][VARIABLE_INDEX:0]: variable ID held in each slot.
- `new_assignment`  output  1: value to assign to the implied variable.
- `implied_variable`  output  VARIABLE_INDEX+1: variable ID of the lone unassigned literal.
- `is_unit_clause`  output  1: clause is unit this result.

## Operation
- Active-unassigned vector: `cand = unassign & clause_mask`.
- Unit condition: `is_unit_clause = 1` iff `cand` has exactly one bit set (population count == 1).
  - Zero set bits gives 0; two or more gives 0.
  - Assigned literals are not checked for truth; the solver guarantees non-unit conflicts/satisfied clauses are handled elsewhere.
- When unit, with k = index of the single set bit of `cand`:
  - `implied_variable = variable[k]`.
  - `new_assignment = clause_pole[k]`: positive literal implies 1, negated literal implies 0.
- When not unit: `implied_variable = 0`, `new_assignment = 0`.
- Slot i maps to bit i of every vector and to `variable[i]`. There is no reordering.
- `clause_mask = 0` yields non-unit.
- Unassigned flags on masked-out slots never count and never select.
- Input values are treated as-is. There is no X-propagation handling beyond standard 4-state semantics.

## Timing
- Evaluation is combinational; all three outputs are registered in one output stage. Latency is 1 cycle: outputs after rising edge N reflect inputs sampled at edge N.
- No handshake: inputs are sampled every cycle, and a new clause may be presented every cycle (throughput 1 clause/cycle).
- Outputs hold between edges and change only on `clock` rising edge or reset.
- Reset: `reset_n` low asynchronously forces `is_unit_clause = 0`, `new_assignment = 0`, `implied_variable = 0`, regardless of clock. The outputs stay 0 while `reset_n` is low.
- First evaluated result appears at the first rising edge after `reset_n` deasserts (deassertion assumed synchronous to `clock` by the system).
- Reset asserted mid-stream discards the pending result; there is no recovery of the in-flight clause.
- Simultaneous input change at an edge: the value stable at the edge (setup met) is the one evaluated.

## Test plan
- Reset:
  - Stimulus: `reset_n = 0` with arbitrary inputs, including unit-clause inputs.
  - Required: all outputs 0 immediately (asynchronous) and across edges.
  - Then `reset_n = 1` with all inputs 0: outputs remain 0.
- Unit, negative literal:
  - Stimulus: `unassign = 5'b10000`, `clause_mask = 5'b11111`, `clause_pole = 5'b00000`, `variable[4] = 7'd42`.
  - Required, next edge: `is_unit_clause = 1`, `implied_variable = 42`, `new_assignment = 0`.
- Unit, positive literal:
  - Stimulus: same as above but `clause_pole = 5'b11111`, `variable[4] = 7'd99`.
  - Required: `is_unit_clause = 1`, `implied_variable = 99`, `new_assignment = 1`.
- Multiple unassigned:
  - `unassign = 5'b10001`, mask all ones: `is_unit_clause = 0`, other outputs 0.
  - `unassign = 5'b11111`: `is_unit_clause = 0`.
  - `unassign = 5'b00000`: `is_unit_clause = 0`.
- Mask filtering:
  - Stimulus: `unassign = 5'b10100`, `clause_mask = 5'b00111`, `clause_pole = 5'b00100`, `variable[2] = 7'd5`.
  - Required: `is_unit_clause = 1`, `implied_variable = 5`, `new_assignment = 1`.
  - Masked slot 4 is ignored.
- Back-to-back and reset mid-stream:
  - Alternate unit/non-unit clauses every cycle: each output matches the previous edge's inputs, no bubbles.
  - Assert `reset_n` between edges: outputs clear at once, without waiting for a clock edge.
